load_store_unit: RTL and testbench

//  Memory stage of the RISC-V core. Takes the ALU result as the effective address
//  for loads/stores, drives a single-outstanding request/grant/rvalid data-memory

---
 rtl/load_store_unit_pkg.sv | 29 ++
 rtl/load_store_unit_if.sv | 56 +++++
 rtl/load_store_unit_align.sv | 78 +++++++
 rtl/load_store_unit.sv | 150 +++++++++++++++
 tb/tb_load_store_unit.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit_pkg
//  Description : Shared constants for the load/store unit: data width,
//                RISC-V load/store funct3 codes and LSU FSM state encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package load_store_unit_pkg;

    localparam int XLEN = 32;

    typedef logic [2:0] funct3_t;

    // Load/store width codes (funct3 field of LOAD/STORE opcodes)
    localparam funct3_t F3_B  = 3'b000;
    localparam funct3_t F3_H  = 3'b001;
    localparam funct3_t F3_W  = 3'b010;
    localparam funct3_t F3_BU = 3'b100;
    localparam funct3_t F3_HU = 3'b101;

    // LSU FSM state encodings
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_RESP = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit_if
//  Description : Bundles the EX-side request, data-memory port and writeback
//                response signals of the load/store unit.
//                slave  : the LSU view (accepts requests, drives memory port)
//                master : the environment view (EX stage, memory, writeback)
//  Revision    : 1.0 - initial release
// ============================================================================
interface load_store_unit_if;
    import load_store_unit_pkg::*;

    // EX-stage request
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            req_we;
    funct3_t         req_funct3;
    logic [4:0]      req_rd;

    // Data-memory port
    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic            mem_we;
    logic [3:0]      mem_be;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_gnt;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;

    // Writeback response
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_rdata;
    logic [4:0]      rsp_rd;
    logic            rsp_wb;
    logic            rsp_err;

    modport slave (
        input  req_valid, req_addr, req_wdata, req_we, req_funct3, req_rd,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output req_ready,
        output mem_req, mem_addr, mem_we, mem_be, mem_wdata,
        output rsp_valid, rsp_rdata, rsp_rd, rsp_wb, rsp_err
    );

    modport master (
        output req_valid, req_addr, req_wdata, req_we, req_funct3, req_rd,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  req_ready,
        input  mem_req, mem_addr, mem_we, mem_be, mem_wdata,
        input  rsp_valid, rsp_rdata, rsp_rd, rsp_wb, rsp_err
    );

endinterface
`default_nettype wire

// File: rtl/load_store_unit_align.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit_align
//  Description : Purely combinational lane logic for the LSU.
//                Ports:
//                  i_addr_lo  [1:0]  byte offset within the word
//                  i_funct3   [2:0]  access width / signedness
//                  i_we              1 = store, 0 = load
//                  i_wdata    [31:0] raw store data
//                  i_rdata    [31:0] raw memory read word
//                  o_be       [3:0]  byte enables
//                  o_wdata    [31:0] lane-replicated store data
//                  o_ld_data  [31:0] lane-selected, extended load data
//                  o_misaligned      access crosses its natural alignment
//                  o_illegal         funct3 not valid for this direction
//  Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit_align
    import load_store_unit_pkg::*;
(
    input  wire logic [1:0]      i_addr_lo,
    input  wire funct3_t         i_funct3,
    input  wire logic            i_we,
    input  wire logic [XLEN-1:0] i_wdata,
    input  wire logic [XLEN-1:0] i_rdata,
    output logic [3:0]           o_be,
    output logic [XLEN-1:0]      o_wdata,
    output logic [XLEN-1:0]      o_ld_data,
    output logic                 o_misaligned,
    output logic                 o_illegal
);

    // Addressed byte/halfword moved down to bit 0
    logic [15:0] w_lane;

    always_comb begin
        w_lane       = 16'(i_rdata >> {i_addr_lo, 3'b000});
        o_be         = 4'b0000;
        o_wdata      = '0;
        o_ld_data    = '0;
        o_misaligned = 1'b0;

        // Stores only have B/H/W; loads additionally have BU/HU
        if (i_we) begin
            o_illegal = i_funct3[2] || (i_funct3[1:0] == 2'b11);
        end else begin
            o_illegal = (i_funct3 inside {3'b011, 3'b110, 3'b111});
        end

        // funct3[1:0] gives the size; funct3[2] selects zero-extension
        case (i_funct3[1:0])
            2'b00: begin
                o_be      = 4'b0001 << i_addr_lo;
                o_wdata   = {4{i_wdata[7:0]}};
                o_ld_data = i_funct3[2] ? {24'b0, w_lane[7:0]}
                                        : {{24{w_lane[7]}}, w_lane[7:0]};
            end
            2'b01: begin
                o_misaligned = i_addr_lo[0];
                o_be         = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_wdata      = {2{i_wdata[15:0]}};
                o_ld_data    = i_funct3[2] ? {16'b0, w_lane}
                                           : {{16{w_lane[15]}}, w_lane};
            end
            2'b10: begin
                o_misaligned = (i_addr_lo != 2'b00);
                o_be         = 4'b1111;
                o_wdata      = i_wdata;
                o_ld_data    = i_rdata;
            end
            default: begin
                o_be = 4'b0000;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Memory stage of the RISC-V core. Accepts one load/store at a
//                time from EX, issues it on a req/gnt/rvalid data-memory port
//                and returns a one-cycle response to writeback. Misaligned or
//                illegal ops are answered with rsp_err without touching memory;
//                a watchdog aborts ops stuck in REQ/WAIT.
//                Ports:
//                  clk    rising-edge clock
//                  rst_n  asynchronous active-low reset
//                  bus    load_store_unit_if.slave (req_*, mem_*, rsp_*)
//                Parameters:
//                  TIMEOUT    cycles in REQ+WAIT before abort; 0 disables
//                  TIMEOUT_W  watchdog counter width, must hold TIMEOUT
//  Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT   = 255,
    parameter int TIMEOUT_W = 8
)(
    input  wire logic         clk,
    input  wire logic         rst_n,
    load_store_unit_if.slave  bus
);

    localparam logic [TIMEOUT_W-1:0] c_wdog_last =
        TIMEOUT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    logic [2:0]           r_state;
    logic [XLEN-1:0]      r_addr;
    logic [XLEN-1:0]      r_wdata;
    logic [XLEN-1:0]      r_rdata;
    logic                 r_we;
    funct3_t              r_funct3;
    logic [4:0]           r_rd;
    logic [TIMEOUT_W-1:0] r_wdog;

    logic                 w_in_idle;
    logic                 w_in_req;
    logic                 w_in_resp;
    logic                 w_in_err;
    logic                 w_timeout;
    logic [1:0]           w_al_addr;
    funct3_t              w_al_funct3;
    logic                 w_al_we;
    logic [3:0]           w_be;
    logic [XLEN-1:0]      w_wdata_rep;
    logic [XLEN-1:0]      w_ld_data;
    logic                 w_misaligned;
    logic                 w_illegal;

    assign w_in_idle = (r_state == S_IDLE);
    assign w_in_req  = (r_state == S_REQ);
    assign w_in_resp = (r_state == S_RESP);
    assign w_in_err  = (r_state == S_ERR);

    // In IDLE the aligner checks the incoming op so an error can be decided
    // at accept; afterwards it works from the registered op.
    assign w_al_addr   = w_in_idle ? bus.req_addr[1:0] : r_addr[1:0];
    assign w_al_funct3 = w_in_idle ? bus.req_funct3    : r_funct3;
    assign w_al_we     = w_in_idle ? bus.req_we        : r_we;

    load_store_unit_align u_align (
        .i_addr_lo    (w_al_addr),
        .i_funct3     (w_al_funct3),
        .i_we         (w_al_we),
        .i_wdata      (r_wdata),
        .i_rdata      (bus.mem_rdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata_rep),
        .o_ld_data    (w_ld_data),
        .o_misaligned (w_misaligned),
        .o_illegal    (w_illegal)
    );

    assign w_timeout = (TIMEOUT != 0) && (r_wdog == c_wdog_last);

    // A handshake arriving on the watchdog's final cycle still wins: the
    // memory has already committed to the access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_we     <= 1'b0;
            r_funct3 <= '0;
            r_rd     <= '0;
            r_wdog   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_wdog <= '0;
                    if (bus.req_valid) begin
                        r_addr   <= bus.req_addr;
                        r_wdata  <= bus.req_wdata;
                        r_we     <= bus.req_we;
                        r_funct3 <= bus.req_funct3;
                        r_rd     <= bus.req_rd;
                        r_state  <= (w_misaligned || w_illegal) ? S_ERR : S_REQ;
                    end
                end
                S_REQ: begin
                    r_wdog <= r_wdog + 1'b1;
                    if (bus.mem_gnt) begin
                        r_state <= r_we ? S_RESP : S_WAIT;
                    end else if (w_timeout) begin
                        r_state <= S_ERR;
                    end
                end
                S_WAIT: begin
                    r_wdog <= r_wdog + 1'b1;
                    if (bus.mem_rvalid) begin
                        r_rdata <= w_ld_data;
                        r_state <= S_RESP;
                    end else if (w_timeout) begin
                        r_state <= S_ERR;
                    end
                end
                S_RESP, S_ERR: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = w_in_idle;

    // Memory port is quiet outside REQ
    assign bus.mem_req   = w_in_req;
    assign bus.mem_addr  = w_in_req ? {r_addr[XLEN-1:2], 2'b00} : '0;
    assign bus.mem_we    = w_in_req && r_we;
    assign bus.mem_be    = w_in_req ? w_be : 4'b0000;
    assign bus.mem_wdata = (w_in_req && r_we) ? w_wdata_rep : '0;

    // Response fields are zero outside the single response cycle
    assign bus.rsp_valid = w_in_resp || w_in_err;
    assign bus.rsp_rdata = (w_in_resp && !r_we) ? r_rdata : '0;
    assign bus.rsp_rd    = bus.rsp_valid ? r_rd : 5'd0;
    assign bus.rsp_wb    = w_in_resp && !r_we && (r_rd != 5'd0);
    assign bus.rsp_err   = w_in_err;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Self-checking bench for load_store_unit. Expected responses
//                are queued when an op is driven and compared when the DUT
//                raises rsp_valid; memory-port fields and latencies are
//                checked inline.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    load_store_unit_if bus();

    load_store_unit #(
        .TIMEOUT   (8),
        .TIMEOUT_W (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        wb;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Response scoreboard
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_rdata", bus.rsp_rdata, e.rdata);
                check("rsp_rd",    32'(bus.rsp_rd),  32'(e.rd));
                check("rsp_wb",    32'(bus.rsp_wb),  32'(e.wb));
                check("rsp_err",   32'(bus.rsp_err), 32'(e.err));
            end
        end
    end

    // Presents one op for one cycle; returns at cycle T+1 (negedge)
    task automatic accept(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [4:0] rd,
                          input logic [31:0] exp_rdata, input logic exp_err);
        exp_t e;
        @(negedge clk);
        check("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_rd     = rd;
        e.rdata = exp_rdata;
        e.rd    = rd;
        e.err   = exp_err;
        e.wb    = !we && !exp_err && (rd != 5'd0);
        sb.push_back(e);
        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
        bus.req_rd     = 5'($urandom);
    endtask

    task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [4:0] rd,
                          input logic [31:0] rdata, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                          input logic exp_err, input int gnt_dly);
        logic [31:0] wa;
        accept(we, f3, addr, wdata, rd, exp_rdata, exp_err);
        if (exp_err) begin
            check("err_no_mem_req", 32'(bus.mem_req), 32'd0);
            check("err_rsp_t1",     32'(bus.rsp_valid), 32'd1);
            @(negedge clk);
            check("err_ready_after", 32'(bus.req_ready), 32'd1);
        end else begin
            for (int i = 0; i < gnt_dly; i++) begin
                check("mem_req_held", 32'(bus.mem_req), 32'd1);
                @(negedge clk);
            end
            wa = addr & 32'hFFFF_FFFC;
            check("mem_req",   32'(bus.mem_req), 32'd1);
            check("req_busy",  32'(bus.req_ready), 32'd0);
            check("mem_addr",  bus.mem_addr, wa);
            check("mem_be",    32'(bus.mem_be), 32'(exp_be));
            check("mem_we",    32'(bus.mem_we), 32'(we));
            if (we) check("mem_wdata", bus.mem_wdata, exp_wdata);
            bus.mem_gnt = 1'b1;
            @(negedge clk);
            bus.mem_gnt = 1'b0;
            if (!we) begin
                check("load_wait_no_rsp", 32'(bus.rsp_valid), 32'd0);
                check("mem_req_dropped",  32'(bus.mem_req), 32'd0);
                @(negedge clk);
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = rdata;
                @(negedge clk);
                bus.mem_rvalid = 1'b0;
                bus.mem_rdata  = $urandom;
            end
            check("rsp_latency", 32'(bus.rsp_valid), 32'd1);
            @(negedge clk);
            check("rsp_one_cycle", 32'(bus.rsp_valid), 32'd0);
            check("ready_after",   32'(bus.req_ready), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1);
    end

    initial begin
        int n_req;
        bus.req_valid  = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = '0;
        bus.req_rd     = '0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;

        // Reset state
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_mem_req",   32'(bus.mem_req), 32'd0);
        check("rst_mem_be",    32'(bus.mem_be), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_err",   32'(bus.rsp_err), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Loads
        run_op(0, F3_W,  32'h100, 0, 5'd5,  32'hDEADBEEF, 4'b1111, 0, 32'hDEADBEEF, 0, 0);
        run_op(0, F3_B,  32'h103, 0, 5'd6,  32'h80112233, 4'b1000, 0, 32'hFFFFFF80, 0, 1);
        run_op(0, F3_BU, 32'h103, 0, 5'd7,  32'h80112233, 4'b1000, 0, 32'h00000080, 0, 0);
        run_op(0, F3_HU, 32'h102, 0, 5'd8,  32'h80112233, 4'b1100, 0, 32'h00008011, 0, 2);
        run_op(0, F3_H,  32'h102, 0, 5'd9,  32'h80112233, 4'b1100, 0, 32'hFFFF8011, 0, 0);
        run_op(0, F3_H,  32'h100, 0, 5'd10, 32'h80112233, 4'b0011, 0, 32'h00002233, 0, 0);
        run_op(0, F3_B,  32'h101, 0, 5'd0,  32'h80112233, 4'b0010, 0, 32'h00000022, 0, 0);

        // Stores
        run_op(1, F3_H, 32'h202, 32'h1234ABCD, 5'd3, 0, 4'b1100, 32'hABCDABCD, 0, 0, 0);
        run_op(1, F3_B, 32'h201, 32'h0000005A, 5'd4, 0, 4'b0010, 32'h5A5A5A5A, 0, 0, 1);
        run_op(1, F3_W, 32'h204, 32'hCAFEF00D, 5'd2, 0, 4'b1111, 32'hCAFEF00D, 0, 0, 3);

        // Misaligned / illegal
        run_op(0, F3_W,   32'h101, 0, 5'd12, 0, 4'b0000, 0, 0, 1, 0);
        run_op(1, 3'b011, 32'h200, 0, 5'd13, 0, 4'b0000, 0, 0, 1, 0);
        run_op(0, 3'b110, 32'h200, 0, 5'd14, 0, 4'b0000, 0, 0, 1, 0);
        run_op(0, F3_H,   32'h103, 0, 5'd15, 0, 4'b0000, 0, 0, 1, 0);
        run_op(1, F3_W,   32'h202, 0, 5'd16, 0, 4'b0000, 0, 0, 1, 0);

        // Watchdog: gnt never arrives
        accept(0, F3_W, 32'h300, 0, 5'd17, 0, 1);
        n_req = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.mem_req !== 1'b1) break;
            n_req++;
            @(negedge clk);
        end
        check("wdog_req_cycles", 32'(n_req), 32'd8);
        check("wdog_rsp_valid",  32'(bus.rsp_valid), 32'd1);
        @(negedge clk);
        check("wdog_ready", 32'(bus.req_ready), 32'd1);

        // Reset asserted while waiting for rvalid
        accept(0, F3_W, 32'h400, 0, 5'd11, 32'h0, 0);
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        check("mid_wait_no_req", 32'(bus.mem_req), 32'd0);
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("mid_rst_ready",   32'(bus.req_ready), 32'd1);
        check("mid_rst_rsp",     32'(bus.rsp_valid), 32'd0);
        check("mid_rst_rsp_rd",  32'(bus.rsp_rd), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h12345678;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        check("late_rvalid_ignored", 32'(bus.rsp_valid), 32'd0);
        check("late_rvalid_ready",   32'(bus.req_ready), 32'd1);
        run_op(0, F3_W, 32'h404, 0, 5'd19, 32'h0BADF00D, 4'b1111, 0, 32'h0BADF00D, 0, 0);

        repeat (2) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
